// File: rtl/conv_output_streamer.sv
// Buffers one single-cycle convolution output frame and replays it as a valid/ready element stream.
// Optional CONV_STREAM_COORD_EN adds m_ch/m_row/m_col coordinate outputs for each beat.
module conv_output_streamer #(
    parameter int ELEM_WIDTH       = 8,
    parameter int MAX_OUT_CHANNELS = 16,
    parameter int MAX_OUT_HEIGHT   = 28,
    parameter int MAX_OUT_WIDTH    = 28,
    parameter int MAX_NUM_ELEMS    = MAX_OUT_CHANNELS * MAX_OUT_HEIGHT * MAX_OUT_WIDTH,
    parameter int MAX_DATA_WIDTH   = MAX_NUM_ELEMS * ELEM_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_valid,
    input  logic [MAX_DATA_WIDTH-1:0] frame_data,
    input  logic [7:0]                out_channels,
    input  logic [7:0]                out_height,
    input  logic [7:0]                out_width,
    input  logic                      ovf_clr,
    output logic                      frame_ready,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ELEM_WIDTH-1:0]     m_data,
    output logic                      m_last,
`ifdef CONV_STREAM_COORD_EN
    output logic [7:0]                m_ch,
    output logic [7:0]                m_row,
    output logic [7:0]                m_col,
`endif
    output logic                      overflow
);

    localparam int IDX_W = (MAX_NUM_ELEMS > 1) ? $clog2(MAX_NUM_ELEMS) : 1;
    localparam logic [23:0] MAX_ELEMS_24 = 24'(MAX_NUM_ELEMS);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        index;
    logic [15:0]             count;
    logic [ELEM_WIDTH-1:0]   buf_q [MAX_NUM_ELEMS];

    logic [23:0]             prod;
    logic [15:0]             cap_count;
    logic                    handshake;
    logic                    capture;
    logic                    drop;
    logic [IDX_W-1:0]        idx_inc;

    // Handshake semantics: a beat transfers on any cycle with m_valid & m_ready;
    // m_valid never drops and m_data/m_last never change until that transfer.
    always_comb begin
        prod        = 24'(out_channels) * 24'(out_height) * 24'(out_width);
        cap_count   = (prod > MAX_ELEMS_24) ? MAX_ELEMS_24[15:0] : prod[15:0];
        handshake   = m_valid & m_ready;
        frame_ready = (state == IDLE) | (handshake & m_last);
        capture     = frame_valid & frame_ready;
        drop        = frame_valid & ~frame_ready;
        idx_inc     = index + 1'b1;
    end

    // Frame storage needs no reset: it is always rewritten before being read.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < MAX_NUM_ELEMS; i++) begin
                buf_q[i] <= frame_data[i*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            index    <= '0;
            count    <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            if (capture) begin
                count <= cap_count;
                index <= '0;
                if (cap_count != 16'd0) begin
                    state   <= STREAM;
                    m_valid <= 1'b1;
                    m_data  <= frame_data[ELEM_WIDTH-1:0];
                    m_last  <= (cap_count == 16'd1);
                end else begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    m_data  <= '0;
                end
            end else if (handshake) begin
                if (m_last) begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    m_data  <= '0;
                end else begin
                    index  <= idx_inc;
                    m_data <= buf_q[idx_inc];
                    m_last <= (16'(idx_inc) == count - 16'd1);
                end
            end
        end
    end

`ifdef CONV_STREAM_COORD_EN
    logic [7:0] dim_h;
    logic [7:0] dim_w;

    // Coordinates walk col fastest, then row, then channel, using the captured dims.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ch  <= '0;
            m_row <= '0;
            m_col <= '0;
            dim_h <= '0;
            dim_w <= '0;
        end else if (capture) begin
            m_ch  <= '0;
            m_row <= '0;
            m_col <= '0;
            dim_h <= out_height;
            dim_w <= out_width;
        end else if (handshake && !m_last) begin
            if (m_col == dim_w - 8'd1) begin
                m_col <= '0;
                if (m_row == dim_h - 8'd1) begin
                    m_row <= '0;
                    m_ch  <= m_ch + 8'd1;
                end else begin
                    m_row <= m_row + 8'd1;
                end
            end else begin
                m_col <= m_col + 8'd1;
            end
        end
    end
`endif

endmodule
